// File: rtl/apb_pkg.sv
// Shared types and default sizing for the APB master/slave block.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

    localparam int DEF_ADDR_WIDTH = 10;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_MEM_DEPTH  = 1024;

endpackage

// File: rtl/apb_slave.sv
// Zero-wait-state APB memory slave: word-addressed storage with an error
// response for addresses beyond the populated depth.
module apb_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
    input  logic                  apb_clk,
    input  logic                  rst,
    input  logic                  psel,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic [DATA_WIDTH-1:0] prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
    logic [31:0]           addr_ext;
    logic [IDX_W-1:0]      idx;
    logic                  in_range;
    logic                  access;

    // Range check is done on a zero-extended copy so any ADDR_WIDTH works.
    assign addr_ext = 32'(paddr);
    assign in_range = (addr_ext < 32'(MEM_DEPTH));
    assign idx      = addr_ext[IDX_W-1:0];
    assign access   = psel & penable;

    assign pready  = access;
    assign pslverr = access & ~in_range;
    assign prdata  = (access & in_range) ? mem[idx] : '0;

    always_ff @(posedge apb_clk) begin
        if (rst) begin
            for (int i = 0; i < MEM_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (access & pwrite & in_range) begin
            mem[idx] <= pwdata;
        end
    end

endmodule

// File: rtl/apb_master_slave.sv
// APB master FSM that issues one transfer every three cycles from the user
// request inputs, paired with an internal memory slave.
module apb_master_slave
    import apb_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
    input  logic                  apb_clk,
    input  logic                  apb_resetn,
    input  logic [DATA_WIDTH-1:0] apb_wdata,
    input  logic [ADDR_WIDTH-1:0] apb_addr,
    input  logic                  apb_wr_rd,
    output logic [DATA_WIDTH-1:0] apb_rdata,
    output logic                  apb_slverr
);

    apb_state_t state, state_nxt;

    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;
    logic                  done;

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_wr;

    always_ff @(posedge apb_clk) begin
        if (apb_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        psel      = 1'b0;
        penable   = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = SETUP;
            end
            SETUP: begin
                psel      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (pready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Bus address/data come straight from the request registers, which only
    // load in IDLE, so they stay stable for the whole SETUP/ACCESS window.
    assign paddr  = req_addr;
    assign pwdata = req_wdata;
    assign pwrite = req_wr;

    always_ff @(posedge apb_clk) begin
        if (apb_resetn) begin
            req_addr   <= '0;
            req_wdata  <= '0;
            req_wr     <= 1'b0;
            apb_rdata  <= '0;
            apb_slverr <= 1'b0;
        end else begin
            if (state == IDLE) begin
                req_addr  <= apb_addr;
                req_wdata <= apb_wdata;
                req_wr    <= (apb_wr_rd == 1'b1);
            end
            if (done) begin
                apb_slverr <= pslverr;
                if (!pwrite) begin
                    apb_rdata <= prdata;
                end
            end
        end
    end

    apb_slave #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_slave (
        .apb_clk (apb_clk),
        .rst     (apb_resetn),
        .psel    (psel),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

endmodule

// File: tb/tb_apb_master_slave.sv
// Scoreboard bench for apb_master_slave: stimulus pushes expected results from
// a behavioural memory model; a monitor pops them at each transfer completion.
module tb_apb_master_slave;
    import apb_pkg::*;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int MD = 1024;

    logic          apb_clk    = 1'b0;
    logic          apb_resetn = 1'b1;
    logic [DW-1:0] apb_wdata  = '0;
    logic [AW-1:0] apb_addr   = '0;
    logic          apb_wr_rd  = 1'b0;
    logic [DW-1:0] apb_rdata;
    logic          apb_slverr;

    apb_master_slave #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .MEM_DEPTH  (MD)
    ) dut (
        .apb_clk    (apb_clk),
        .apb_resetn (apb_resetn),
        .apb_wdata  (apb_wdata),
        .apb_addr   (apb_addr),
        .apb_wr_rd  (apb_wr_rd),
        .apb_rdata  (apb_rdata),
        .apb_slverr (apb_slverr)
    );

    always #5 apb_clk = ~apb_clk;

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          slverr;
        logic [AW-1:0] addr;
        logic          wr;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] model_mem [MD];
    logic [DW-1:0] model_rdata;
    logic          model_slverr;
    int            total = 0;
    int            bad   = 0;

    logic          prev_setup = 1'b0;
    logic [AW-1:0] prev_addr;
    logic          prev_wr;
    logic [DW-1:0] prev_wdata;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < MD; i++) model_mem[i] = '0;
        model_rdata  = '0;
        model_slverr = 1'b0;
    endfunction

    task automatic scramble();
        apb_wr_rd = 1'($urandom);
        apb_addr  = AW'($urandom);
        apb_wdata = $urandom;
    endtask

    // Called at a negedge right before an IDLE sampling edge; returns at the
    // negedge after the completion edge, ready for the next request.
    task automatic do_xfer(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        exp_t e;
        bit   inr;
        inr       = (int'(addr) < MD);
        apb_wr_rd = wr;
        apb_addr  = addr;
        apb_wdata = data;
        if (wr) begin
            if (inr) model_mem[int'(addr)] = data;
        end else begin
            model_rdata = inr ? model_mem[int'(addr)] : '0;
        end
        model_slverr = !inr;
        e = '{rdata: model_rdata, slverr: model_slverr, addr: addr, wr: wr};
        sb_q.push_back(e);
        @(negedge apb_clk); scramble();
        @(negedge apb_clk); scramble();
        @(negedge apb_clk);
    endtask

    task automatic do_reset(input int cycles);
        apb_resetn = 1'b1;
        repeat (cycles) @(negedge apb_clk);
        model_reset();
        sb_q.delete();
        chk("rst_rdata", apb_rdata, model_rdata);
        chk("rst_slverr", apb_slverr, model_slverr);
        chk("rst_state", dut.state, IDLE);
        chk("rst_psel_penable", {dut.psel, dut.penable}, 2'b00);
        chk("rst_req_addr", dut.req_addr, 0);
        apb_resetn = 1'b0;
    endtask

    // Completion monitor: an ACCESS cycle out of reset completes on the next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge apb_clk);
            #2;
            if (!apb_resetn && dut.psel && dut.penable) begin
                @(posedge apb_clk);
                #1;
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_completion: got a transfer, expected none (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk($sformatf("rdata wr=%0d addr=%0d", e.wr, e.addr), apb_rdata, e.rdata);
                    chk($sformatf("slverr wr=%0d addr=%0d", e.wr, e.addr), apb_slverr, e.slverr);
                end
            end
        end
    end

    // Bus protocol monitor.
    initial begin
        forever begin
            @(negedge apb_clk);
            #2;
            if (apb_resetn) begin
                prev_setup = 1'b0;
            end else begin
                if (dut.penable) chk("penable_without_psel", dut.psel, 1);
                if (prev_setup) begin
                    chk("setup_then_access", {dut.psel, dut.penable}, 2'b11);
                    chk("paddr_stable", dut.paddr, prev_addr);
                    chk("pwrite_stable", dut.pwrite, prev_wr);
                    chk("pwdata_stable", dut.pwdata, prev_wdata);
                end
                prev_setup = dut.psel && !dut.penable;
                prev_addr  = dut.paddr;
                prev_wr    = dut.pwrite;
                prev_wdata = dut.pwdata;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] d;
        do_reset(3);

        for (int a = 0; a < 5; a++) do_xfer(1'b0, AW'(a), DW'($urandom));

        for (int a = 0; a < 5; a++) begin
            d = $urandom;
            do_xfer(1'b1, AW'(a), d);
        end
        for (int a = 0; a < 5; a++) do_xfer(1'b0, AW'(a), '0);

        do_xfer(1'b1, 12'd3, 32'hDEADBEEF);
        do_xfer(1'b0, 12'd3, '0);

        do_xfer(1'b0, 12'd928, '0);
        do_xfer(1'b1, 12'd4000, 32'h12345678);
        do_xfer(1'b0, 12'd4000, '0);
        do_xfer(1'b0, 12'd928, '0);
        do_xfer(1'b0, 12'd3, '0);

        do_xfer(1'b1, 12'd7, 32'hCAFE0007);
        do_xfer(1'b1, 12'd7, 32'hCAFE0007);
        do_xfer(1'b0, 12'd7, '0);
        do_xfer(1'b0, 12'd7, '0);
        do_xfer(1'b1, 12'd8, 32'h0BADF00D);

        // Abort a write to addr 2 by asserting reset during its ACCESS cycle.
        apb_wr_rd = 1'b1;
        apb_addr  = 12'd2;
        apb_wdata = 32'hA5A5A5A5;
        @(negedge apb_clk);
        @(negedge apb_clk);
        chk("abort_in_access", dut.state, ACCESS);
        apb_resetn = 1'b1;
        @(negedge apb_clk);
        chk("abort_mem2", dut.u_slave.mem[2], 0);
        chk("abort_state", dut.state, IDLE);
        chk("abort_rdata", apb_rdata, 0);
        chk("abort_slverr", apb_slverr, 0);
        do_reset(1);
        do_xfer(1'b0, 12'd2, '0);
        do_xfer(1'b0, 12'd3, '0);

        for (int n = 0; n < 60; n++) begin
            logic [AW-1:0] a;
            a = ($urandom_range(3, 0) == 0) ? AW'($urandom) : AW'($urandom_range(15, 0));
            do_xfer(1'($urandom), a, $urandom);
        end

        @(negedge apb_clk);
        chk("scoreboard_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_master_slave.md
APB_MASTER_SLAVE -- requirements
Module: apb_master_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, user address width.
REQ-002 Parameter DATA_WIDTH, default 32, data width.
REQ-003 Parameter MEM_DEPTH, default 1024, number of slave memory words.
REQ-004 apb_clk  input  1  single clock; all state updates on rising edge.
REQ-005 apb_resetn  input  1  reset; synchronous, active-high (asserted when 1, sampled on apb_clk rising edge).
REQ-006 apb_wdata  input  DATA_WIDTH  write data for the user request.
REQ-007 apb_addr  input  ADDR_WIDTH  word address for the user request.
REQ-008 apb_wr_rd  input  1  request type; 1 = write, any other value (0/X) = read.
REQ-009 apb_rdata  output  DATA_WIDTH  data returned by the last completed read.
REQ-010 apb_slverr  output  1  error status of the last completed transfer.
REQ-011 Port order SHALL be exactly: apb_clk, apb_resetn, apb_wdata, apb_addr, apb_wr_rd, apb_rdata, apb_slverr (positional instantiation).

Function
REQ-012 Internal APB master FSM SHALL have states IDLE, SETUP, ACCESS; internal bus: psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr.
REQ-013 IDLE: psel=0, penable=0; on each clock edge, sample apb_addr, apb_wdata, apb_wr_rd into request registers and go to SETUP.
REQ-014 SETUP: psel=1, penable=0, paddr/pwdata/pwrite from request registers; next state ACCESS.
REQ-015 ACCESS: psel=1, penable=1; if pready=1 complete transfer and return to IDLE, else remain in ACCESS with all bus signals stable.
REQ-016 Slave SHALL assert pready=1 combinationally in every ACCESS cycle (zero wait states); one transfer = 3 cycles (IDLE, SETUP, ACCESS).
REQ-017 Write: slave SHALL write pwdata to mem[paddr] on the clock edge ending ACCESS, when paddr < MEM_DEPTH.
REQ-018 Read: slave SHALL drive prdata = mem[paddr] combinationally in ACCESS; master SHALL register it into apb_rdata on the edge ending ACCESS.
REQ-019 apb_rdata SHALL hold its value between reads; writes SHALL NOT change it.
REQ-020 Address paddr >= MEM_DEPTH: pslverr=1, write ignored, prdata=0; apb_slverr SHALL be updated with pslverr at every transfer completion (0 for in-range).
REQ-021 Repeating the same request back-to-back SHALL be harmless (idempotent write, repeated read).
REQ-022 Input changes during SETUP/ACCESS SHALL NOT affect the in-flight transfer.

Reset
REQ-023 While apb_resetn=1: FSM to IDLE, psel=penable=0, apb_rdata=0, apb_slverr=0, request registers=0, all memory words=0.
REQ-024 Reset asserted mid-transfer SHALL abort it with no memory write; first transfer starts the cycle after reset deasserts.

Structure
REQ-025 Package apb_pkg SHALL hold the FSM state enum (IDLE, SETUP, ACCESS) and default width/depth constants.
REQ-026 One sub-module apb_slave SHALL contain memory, pready/pslverr/prdata logic; apb_master_slave holds FSM and output registers.

Verification
REQ-027 Write addr 0..4 with data D0..D4 (each held 4 cycles), then read 0..4 -> apb_rdata = D0..D4 in order, apb_slverr=0.
REQ-028 Per address: write 0xDEADBEEF to addr 3, then read addr 3 -> apb_rdata=0xDEADBEEF within 3 cycles of read request.
REQ-029 Read addr 0..4 immediately after reset -> apb_rdata=0, apb_slverr=0.
REQ-030 ADDR_WIDTH=12, write then read addr 4000 -> apb_slverr=1, apb_rdata=0, no memory word modified.
REQ-031 Assert reset during ACCESS of a write to addr 2 -> mem[2] stays 0, FSM in IDLE, outputs 0.
REQ-032 Protocol checks: penable only with psel; SETUP always followed by ACCESS; paddr/pwrite/pwdata stable SETUP through ACCESS.
